// File: rtl/mmc3x3_pkg.sv
// Shared definitions for the 3x3 matrix-vector sequencer.
//   - default data/coefficient widths and coefficient fraction bits
//   - register offsets relative to the block base address
//   - FSM state encodings
//   - identity-bank pattern used at reset
package mmc3x3_pkg;

    localparam int DW_DEF   = 14;
    localparam int CW_DEF   = 16;
    localparam int FRAC_DEF = 14;

    localparam int NCOEF = 9;

    // Coefficient k lives at OFS_COEF0 + COEF_STRIDE*k, k = row*3 + col.
    localparam logic [19:0] OFS_COEF0   = 20'h00000;
    localparam int          COEF_STRIDE = 4;
    localparam logic [19:0] OFS_CTRL    = 20'h00024;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    // Bit k set means coefficient k is 1.0 in the identity bank.
    localparam logic [NCOEF-1:0] IDENT_MASK = 9'b100_010_001;

endpackage

// File: rtl/mmc3x3_round_sat.sv
// Combinational round-half-up and saturate from the accumulator width
// down to the signed output sample width.
//   acc_i : signed accumulator value (AW bits, FRAC fractional bits)
//   y_o   : rounded, clamped signed result (DW bits)
module mmc3x3_round_sat #(
    parameter int AW   = 32,
    parameter int DW   = 14,
    parameter int FRAC = 14
) (
    input  logic signed [AW-1:0] acc_i,
    output logic signed [DW-1:0] y_o
);

    // One extra bit so adding the half-LSB can never wrap.
    localparam logic signed [AW:0] HALF = {{(AW+1-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [AW:0] MAXV = {{(AW+2-DW){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW:0] MINV = ~MAXV;

    logic signed [AW:0] rnd;
    logic signed [AW:0] shr;

    assign rnd = {acc_i[AW-1], acc_i} + HALF;
    assign shr = rnd >>> FRAC;

    always_comb begin
        if (shr > MAXV) begin
            y_o = MAXV[DW-1:0];
        end else if (shr < MINV) begin
            y_o = MINV[DW-1:0];
        end else begin
            y_o = shr[DW-1:0];
        end
    end

endmodule

// File: rtl/mmc3x3_sequencer.sv
// Time-multiplexed 3x3 matrix-vector multiply controller.
// One multiply-accumulator walks the 9 coefficient/sample products of each
// accepted vector; results leave through a valid/ready handshake.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   sys_addr_i/sys_wdata_i/sys_wen_i  register bus (write only)
//   in_valid_i/in_ready_o/in_x*_i     input vector stream
//   out_valid_o/out_ready_i/out_y*_o  result vector stream
//   busy_o                            FSM not IDLE
//   commit_pending_o                  commit requested, not yet copied
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, holds its data stable until that edge.
module mmc3x3_sequencer
    import mmc3x3_pkg::*;
#(
    parameter int          DW   = DW_DEF,
    parameter int          CW   = CW_DEF,
    parameter int          FRAC = FRAC_DEF,
    parameter logic [19:0] BASE = 20'h00000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [19:0]          sys_addr_i,
    input  logic [31:0]          sys_wdata_i,
    input  logic                 sys_wen_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic signed [DW-1:0] in_x0_i,
    input  logic signed [DW-1:0] in_x1_i,
    input  logic signed [DW-1:0] in_x2_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic signed [DW-1:0] out_y0_o,
    output logic signed [DW-1:0] out_y1_o,
    output logic signed [DW-1:0] out_y2_o,
    output logic                 busy_o,
    output logic                 commit_pending_o
);

    localparam int PW = DW + CW;
    localparam int AW = DW + CW + 2;

    logic [1:0]           state_q, state_d;
    logic [3:0]           k_q;
    logic [1:0]           col_q, row_q;
    logic signed [CW-1:0] shadow_q [NCOEF];
    logic signed [CW-1:0] active_q [NCOEF];
    logic                 commit_pending_q;
    logic signed [DW-1:0] x_q [3];
    logic signed [DW-1:0] y_q [3];
    logic signed [AW-1:0] acc_q;

    logic [19:0]          ofs;
    logic                 coef_wen, ctrl_set, accept, do_copy;
    logic [3:0]           coef_idx;
    logic signed [PW-1:0] coef_ext, x_ext, prod;
    logic signed [AW-1:0] acc_sum;
    logic signed [DW-1:0] y_rs;
    logic                 unused_wdata;

    // Register decode: word-aligned offsets below CTRL are coefficients.
    assign ofs      = sys_addr_i - BASE;
    assign coef_wen = sys_wen_i && (ofs < OFS_CTRL) && (ofs[1:0] == 2'b00);
    assign coef_idx = ofs[5:2];
    assign ctrl_set = sys_wen_i && (ofs == OFS_CTRL) && sys_wdata_i[0];
    assign unused_wdata = ^sys_wdata_i[31:CW];

    // Inputs are refused while a commit is pending, so the bank copy in
    // IDLE never coincides with accepting a vector.
    assign in_ready_o = (state_q == ST_IDLE) && !commit_pending_q;
    assign accept     = in_ready_o && in_valid_i;
    assign do_copy    = (state_q == ST_IDLE) && commit_pending_q;

    // Single shared MAC; the accumulator restarts at the first column of each row.
    assign coef_ext = {{DW{active_q[k_q][CW-1]}}, active_q[k_q]};
    assign x_ext    = {{CW{x_q[col_q][DW-1]}}, x_q[col_q]};
    assign prod     = coef_ext * x_ext;
    assign acc_sum  = ((col_q == 2'd0) ? '0 : acc_q) + {{2{prod[PW-1]}}, prod};

    mmc3x3_round_sat #(.AW(AW), .DW(DW), .FRAC(FRAC)) u_round_sat (
        .acc_i (acc_sum),
        .y_o   (y_rs)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)         state_d = ST_CALC;
            ST_CALC: if (k_q == 4'd8)    state_d = ST_OUT;
            ST_OUT:  if (out_ready_i)    state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            col_q   <= '0;
            row_q   <= '0;
            acc_q   <= '0;
            for (int i = 0; i < 3; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (accept) begin
                x_q[0] <= in_x0_i;
                x_q[1] <= in_x1_i;
                x_q[2] <= in_x2_i;
                k_q    <= '0;
                col_q  <= '0;
                row_q  <= '0;
            end
            if (state_q == ST_CALC) begin
                acc_q <= acc_sum;
                k_q   <= k_q + 4'd1;
                if (col_q == 2'd2) begin
                    col_q      <= '0;
                    row_q      <= row_q + 2'd1;
                    y_q[row_q] <= y_rs;
                end else begin
                    col_q <= col_q + 2'd1;
                end
            end
        end
    end

    // Coefficient banks. A shadow write coinciding with the copy reaches
    // the shadow only, since the copy reads the pre-edge shadow value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NCOEF; i++) begin
                shadow_q[i] <= IDENT_MASK[i] ? CW'(1 << FRAC) : '0;
                active_q[i] <= IDENT_MASK[i] ? CW'(1 << FRAC) : '0;
            end
            commit_pending_q <= 1'b0;
        end else begin
            if (coef_wen) begin
                shadow_q[coef_idx] <= sys_wdata_i[CW-1:0];
            end
            if (do_copy) begin
                for (int i = 0; i < NCOEF; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
            if (ctrl_set) begin
                commit_pending_q <= 1'b1;
            end else if (do_copy) begin
                commit_pending_q <= 1'b0;
            end
        end
    end

    assign out_valid_o      = (state_q == ST_OUT);
    assign busy_o           = (state_q != ST_IDLE);
    assign commit_pending_o = commit_pending_q;
    assign out_y0_o         = y_q[0];
    assign out_y1_o         = y_q[1];
    assign out_y2_o         = y_q[2];

endmodule
